cardinal_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the cardinal pipeline, replacing the bare PC register with a decoupled fetch stage. Issues sequential fetch addresses to a synchronous instruction memory and buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO. Decode consumes the FIFO through a valid/ready handshake. A branch redirect flushes the FIFO and any in-flight fetch.

---
 rtl/cardinal_fetch_queue.sv | 120 ++++++++++++
 tb/tb_cardinal_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cardinal_fetch_queue.sv
// Decoupled instruction-fetch front end: issues sequential PCs to a synchronous
// instruction memory and queues {instruction, pc} pairs for decode.
module cardinal_fetch_queue #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     INST_W    = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     PC_STEP   = 4,
    parameter logic [PC_W-1:0] WRAP_ADDR = PC_W'(32'hFF80_0000)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_en,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INST_W-1:0]          imem_data,
    output logic                       dec_valid,
    output logic [INST_W-1:0]          dec_inst,
    output logic [PC_W-1:0]            dec_pc,
    input  logic                       dec_ready,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned     PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_W-1:0] PC_MASK = ~(PC_W'(PC_STEP - 1));
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INST_W-1:0] fifo_inst_q [DEPTH];
    logic [PC_W-1:0]   fifo_pc_q   [DEPTH];

    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts entries held plus the response still in flight; pops in the
    // same cycle are deliberately ignored.
    assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign imem_en     = !reset && !redirect && (credit_used < DEPTH_C);
    assign imem_addr   = pc_q;

    assign dec_valid   = (count_q != '0);
    assign dec_inst    = fifo_inst_q[head_q];
    assign dec_pc      = fifo_pc_q[head_q];
    assign occupancy   = count_q;

    assign push = inflight_q && !redirect;
    assign pop  = dec_valid && dec_ready && !redirect;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (redirect) begin
            pc_d    = redirect_pc & PC_MASK;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (imem_en) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = (pc_q == WRAP_ADDR) ? '0 : pc_q + PC_W'(PC_STEP);
            end
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_inst_q[tail_q] <= imem_data;
            fifo_pc_q[tail_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_cardinal_fetch_queue.sv
// Self-checking bench for cardinal_fetch_queue: directed timing checks plus a
// randomized run scored against the program-order PC stream it should deliver.
module tb_cardinal_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] WRAP  = 32'hFF80_0000;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  occupancy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pops     = 0;
    logic [31:0] exp_pc   = '0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc  = '0;

    cardinal_fetch_queue #(
        .PC_W(32), .INST_W(32), .DEPTH(DEPTH), .PC_STEP(4), .WRAP_ADDR(WRAP)
    ) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .dec_valid(dec_valid), .dec_inst(dec_inst),
        .dec_pc(dec_pc), .dec_ready(dec_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for a request appears the next cycle.
    always @(posedge clk) begin
        if (imem_en) imem_data <= imem_addr ^ SALT;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seq_next(input logic [31:0] pc);
        return (pc == WRAP) ? 32'h0 : pc + 32'd4;
    endfunction

    // One cycle: drive inputs at negedge, sample just after, score the handshake
    // that the coming posedge will perform.
    task automatic tick(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        reset = rst; dec_ready = rdy; redirect = rdr; redirect_pc = rpc;
        #1;
        if (rst) begin
            check_eq("rst_no_issue", imem_en, 1'b0);
        end else begin
            if (hold_prev) begin
                check_eq("hold_valid", dec_valid, 1'b1);
                check_eq("hold_pc", dec_pc, hold_pc);
            end
            if (occupancy > 3'(DEPTH)) check_eq("occ_bound", occupancy, DEPTH);
            if (occupancy == 3'(DEPTH)) check_eq("credit_stop", imem_en, 1'b0);
            if (rdr) begin
                check_eq("redir_no_issue", imem_en, 1'b0);
            end else if (dec_valid && rdy) begin
                check_eq("pop_pc", dec_pc, exp_pc);
                check_eq("pop_inst", dec_inst, exp_pc ^ SALT);
                exp_pc = seq_next(exp_pc);
                pops++;
            end
        end
        hold_prev = !rst && !rdr && dec_valid && !rdy;
        hold_pc   = dec_pc;
        if (rst) exp_pc = '0;
        else if (rdr) exp_pc = rpc & ~32'h3;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic wrap_pending;
        logic wrapped;

        // Reset state
        do_reset();
        check_eq("rst_valid", dec_valid, 1'b0);
        check_eq("rst_occ", occupancy, 0);
        check_eq("rst_addr", imem_addr, 0);

        // Reset release latency and back-to-back streaming
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("c0_en", imem_en, 1'b1);
        check_eq("c0_addr", imem_addr, 0);
        check_eq("c0_valid", dec_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("c1_valid", dec_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("c2_valid", dec_valid, 1'b1);
        check_eq("c2_pc", dec_pc, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            check_eq("no_gap", dec_valid, 1'b1);
        end

        // Backpressure saturates the queue, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, '0);
        check_eq("full_occ", occupancy, DEPTH);
        check_eq("full_en", imem_en, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, '0);

        // Redirect with three entries queued
        do_reset();
        for (int i = 0; i < 10 && occupancy != 3'd3; i++) tick(1'b0, 1'b0, 1'b0, '0);
        check_eq("pre_redir_occ", occupancy, 3);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        tick(1'b0, 1'b0, 1'b0, '0);
        check_eq("redir_occ", occupancy, 0);
        check_eq("redir_addr", imem_addr, 32'h100);
        check_eq("redir_r1_valid", dec_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("redir_r2_valid", dec_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("redir_r3_valid", dec_valid, 1'b1);
        check_eq("redir_r3_pc", dec_pc, 32'h100);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, '0);

        // Sequential wrap at WRAP_ADDR
        tick(1'b0, 1'b1, 1'b1, WRAP - 32'd8);
        wrap_pending = 1'b0;
        wrapped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            if (wrap_pending) begin
                check_eq("wrap_addr", imem_addr, 0);
                wrap_pending = 1'b0;
                wrapped = 1'b1;
            end
            if (imem_en && imem_addr == WRAP) wrap_pending = 1'b1;
        end
        check_eq("wrap_seen", wrapped, 1'b1);

        // Redirect coinciding with push and pop, then immediate second redirect
        tick(1'b0, 1'b1, 1'b1, 32'h300);
        tick(1'b0, 1'b1, 1'b1, 32'h200);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("dbl_addr", imem_addr, 32'h200);
        check_eq("dbl_r1_valid", dec_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("dbl_r2_valid", dec_valid, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("dbl_r3_pc", dec_pc, 32'h200);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, '0);

        // Reset while full
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, '0);
        check_eq("pre_rst_occ", occupancy, DEPTH);
        tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check_eq("mid_rst_valid", dec_valid, 1'b0);
        check_eq("mid_rst_occ", occupancy, 0);
        check_eq("mid_rst_addr", imem_addr, 0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic rst, rdr, rdy;
            rst = ($urandom_range(0, 199) == 0);
            rdr = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tick(rst, rdy, rdr, $urandom);
        end
        check_eq("progress", (pops >= 200), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
